// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU: widths, control
// encodings and instruction field constants used by controller and datapath.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADR_W  = 12;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned OPC_W  = 4;

  // Instruction field positions
  localparam int unsigned RI_LSB  = 9;
  localparam int unsigned RI_MSB  = RI_LSB + REG_AW - 1;
  localparam int unsigned ADR9_W  = 9;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'b00,
    SRC_B_ONE  = 2'b01,
    SRC_B_IMM  = 2'b10,
    SRC_B_ZERO = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PC_SEL_ALU  = 2'b00,
    PC_SEL_IMM  = 2'b01,
    PC_SEL_PAGE = 2'b10,
    PC_SEL_HOLD = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    WB_MDR    = 3'b000,
    WB_A      = 3'b001,
    WB_B      = 3'b010,
    WB_ALUOUT = 3'b011,
    WB_NOT_A  = 3'b100
  } wb_sel_e;

  // Opcodes live in IR[15:12]
  localparam logic [OPC_W-1:0] OPC_ALU   = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_JUMP  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_STORE = 4'h3;
  localparam logic [OPC_W-1:0] OPC_BRZ   = 4'h4;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 4'hC;
  localparam logic [OPC_W-1:0] OPC_SUBI  = 4'hD;
  localparam logic [OPC_W-1:0] OPC_ANDI  = 4'hE;
  localparam logic [OPC_W-1:0] OPC_ORI   = 4'hF;

  // Function codes for OPC_ALU live in IR[2:0]
  localparam logic [2:0] FUNC_ADD       = 3'd0;
  localparam logic [2:0] FUNC_SUB       = 3'd1;
  localparam logic [2:0] FUNC_AND       = 3'd2;
  localparam logic [2:0] FUNC_OR        = 3'd3;
  localparam logic [2:0] FUNC_NOT       = 3'd4;
  localparam logic [2:0] FUNC_MOVE_TO   = 3'd5;
  localparam logic [2:0] FUNC_MOVE_FROM = 3'd6;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [ADR_W-1:0] imm);
    return {{(DATA_W - ADR_W){imm[ADR_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// 8x16 register file: R0 accumulator read port, R[ri] read port, one
// synchronous write port. Reads are combinational.
module register_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wadr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] radr,
  output logic [DATA_W-1:0] r0_data,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_N); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wadr] <= wdata;
    end
  end

  assign r0_data = regs[0];
  assign rdata   = regs[radr];

endmodule

// File: rtl/multicycle_datapath.sv
// Datapath of the 16-bit multi-cycle accumulator CPU: PC, IR, MDR, operand
// latches, ALU/ALUout and register file, steered by the controller each cycle.
module multicycle_datapath
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              IR_write,
  input  logic              alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic [1:0]        alu_op,
  input  logic              mem_adr_sel,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [1:0]        pc_sel,
  input  logic              reg_write_en,
  input  logic              reg_write_adr,
  input  logic [2:0]        reg_write_sel,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] inst,
  output logic              zero
);

  logic [ADR_W-1:0]  pc;
  logic [ADR_W-1:0]  pc_next;
  logic              pc_load;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] r0_data;
  logic [DATA_W-1:0] ri_data;
  logic [DATA_W-1:0] rf_wdata;
  logic [REG_AW-1:0] ri;
  logic [REG_AW-1:0] rf_wadr;
  logic [ADR_W-1:0]  imm;

  assign ri  = ir[RI_MSB:RI_LSB];
  assign imm = ir[ADR_W-1:0];

  register_file u_register_file (
    .clk     (clk),
    .rst     (rst),
    .we      (reg_write_en),
    .wadr    (rf_wadr),
    .wdata   (rf_wdata),
    .radr    (ri),
    .r0_data (r0_data),
    .rdata   (ri_data)
  );

  // ALU operand muxes and function
  always_comb begin
    alu_a = alu_src_a ? a : DATA_W'(pc);
    alu_b = '0;
    case (src_b_e'(alu_src_b))
      SRC_B_REG:  alu_b = b;
      SRC_B_ONE:  alu_b = DATA_W'(1);
      SRC_B_IMM:  alu_b = sext_imm(imm);
      SRC_B_ZERO: alu_b = '0;
      default:    alu_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Next-PC selection; unconditional write dominates the branch condition
  always_comb begin
    pc_load = pc_write | (pc_write_cond & zero);
    pc_next = pc;
    case (pc_sel_e'(pc_sel))
      PC_SEL_ALU:  pc_next = alu_result[ADR_W-1:0];
      PC_SEL_IMM:  pc_next = imm;
      PC_SEL_PAGE: pc_next = {pc[ADR_W-1:ADR9_W], ir[ADR9_W-1:0]};
      PC_SEL_HOLD: pc_next = pc;
      default:     pc_next = pc;
    endcase
  end

  // Write-back source and destination; ri comes from the IR before any same-edge load
  always_comb begin
    rf_wadr  = reg_write_adr ? ri : REG_AW'(0);
    rf_wdata = '0;
    case (reg_write_sel)
      WB_MDR:    rf_wdata = mdr;
      WB_A:      rf_wdata = a;
      WB_B:      rf_wdata = b;
      WB_ALUOUT: rf_wdata = alu_out;
      WB_NOT_A:  rf_wdata = ~a;
      default:   rf_wdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      a       <= r0_data;
      b       <= ri_data;
      alu_out <= alu_result;
      if (mem_read) mdr <= mem_rdata;
      if (IR_write) ir <= mem_rdata;
      if (pc_load)  pc <= pc_next;
    end
  end

  assign mem_adr   = mem_adr_sel ? imm : pc;
  assign mem_wdata = a;
  assign inst      = ir;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: stimulus pushes expected output
// values into a queue, a negedge monitor pops and compares them.
module tb_multicycle_datapath;
  import cpu_pkg::*;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic              IR_write;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        alu_op;
  logic              mem_adr_sel;
  logic              pc_write;
  logic              pc_write_cond;
  logic [1:0]        pc_sel;
  logic              reg_write_en;
  logic              reg_write_adr;
  logic [2:0]        reg_write_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] inst;
  logic              zero;

  localparam int K_ADR   = 0;
  localparam int K_INST  = 1;
  localparam int K_WDATA = 2;
  localparam int K_ZERO  = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  multicycle_datapath dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .IR_write      (IR_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .mem_adr_sel   (mem_adr_sel),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_sel        (pc_sel),
    .reg_write_en  (reg_write_en),
    .reg_write_adr (reg_write_adr),
    .reg_write_sel (reg_write_sel),
    .mem_rdata     (mem_rdata),
    .mem_adr       (mem_adr),
    .mem_wdata     (mem_wdata),
    .inst          (inst),
    .zero          (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against the outputs
  exp_t        mon_e;
  logic [15:0] mon_obs;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.kind)
        K_ADR:   mon_obs = 16'(mem_adr);
        K_INST:  mon_obs = inst;
        K_WDATA: mon_obs = mem_wdata;
        default: mon_obs = 16'(zero);
      endcase
      n_cmp++;
      if (mon_obs !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%04h, want 0x%04h", mon_e.name, mon_obs, mon_e.val);
      end
    end
  end

  task automatic expect_out(input string name, input int kind, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic ctl_idle();
    mem_read      = 1'b0;
    IR_write      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    mem_adr_sel   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_sel        = 2'b00;
    reg_write_en  = 1'b0;
    reg_write_adr = 1'b0;
    reg_write_sel = 3'b000;
    mem_rdata     = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_r0(input logic [15:0] v);
    ctl_idle();
    mem_read  = 1'b1;
    mem_rdata = v;
    cyc();
    ctl_idle();
    reg_write_en = 1'b1;
    cyc();
    ctl_idle();
  endtask

  task automatic load_ir(input logic [15:0] v);
    ctl_idle();
    IR_write  = 1'b1;
    mem_rdata = v;
    cyc();
    ctl_idle();
  endtask

  task automatic jump_ir(input logic [15:0] v);
    load_ir(v);
    pc_write = 1'b1;
    pc_sel   = 2'b01;
    cyc();
    ctl_idle();
  endtask

  task automatic reg_wb(input logic dst_ri, input logic [2:0] sel);
    ctl_idle();
    reg_write_en  = 1'b1;
    reg_write_adr = dst_ri;
    reg_write_sel = sel;
    cyc();
    ctl_idle();
  endtask

  task automatic alu_imm(input logic [1:0] op);
    ctl_idle();
    alu_src_a = 1'b1;
    alu_src_b = 2'b10;
    alu_op    = op;
  endtask

  task automatic brz_ctl();
    ctl_idle();
    alu_src_a     = 1'b1;
    alu_src_b     = 2'b00;
    alu_op        = 2'b01;
    pc_write_cond = 1'b1;
    pc_sel        = 2'b10;
  endtask

  task automatic fetch_ctl(input logic [15:0] word);
    ctl_idle();
    mem_read  = 1'b1;
    IR_write  = 1'b1;
    mem_rdata = word;
    alu_src_b = 2'b01;
    pc_write  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_idle();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (mem_adr !== 12'h000) begin
      n_fail++;
      $display("FAIL direct_reset_adr: got 0x%03h, want 0x000", mem_adr);
    end
    n_cmp++;
    if (inst !== 16'h0000) begin
      n_fail++;
      $display("FAIL direct_reset_inst: got 0x%04h, want 0x0000", inst);
    end
    n_cmp++;
    if (zero !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_reset_zero: got %b, want 1", zero);
    end
    expect_out("reset_mem_adr", K_ADR, 16'h0000);
    expect_out("reset_inst", K_INST, 16'h0000);
    expect_out("reset_wdata", K_WDATA, 16'h0000);
    expect_out("reset_zero", K_ZERO, 16'h0001);
    cyc();
    rst = 1'b0;
    cyc();

    // Fetch 0x0005
    fetch_ctl(16'h0005);
    expect_out("fetch_adr", K_ADR, 16'h0000);
    expect_out("fetch_zero", K_ZERO, 16'h0000);
    cyc();
    n_cmp++;
    if (inst !== 16'h0005) begin
      n_fail++;
      $display("FAIL direct_fetch_ir: got 0x%04h, want 0x0005", inst);
    end
    ctl_idle();
    expect_out("fetch_ir", K_INST, 16'h0005);
    expect_out("fetch_pc", K_ADR, 16'h0001);
    cyc();

    // Load from IR address
    mem_adr_sel = 1'b1;
    mem_read    = 1'b1;
    mem_rdata   = 16'h1234;
    expect_out("load_adr", K_ADR, 16'h0005);
    cyc();
    reg_wb(1'b0, 3'b000);
    cyc();
    expect_out("load_r0", K_WDATA, 16'h1234);
    cyc();

    // addi 0xFFE (-2)
    load_r0(16'h0007);
    load_ir(16'hCFFE);
    cyc();
    alu_imm(2'b00);
    expect_out("addi_zero", K_ZERO, 16'h0000);
    cyc();
    reg_wb(1'b0, 3'b011);
    cyc();
    expect_out("addi_r0", K_WDATA, 16'h0005);
    cyc();

    // andi 0x00C
    load_ir(16'hE00C);
    alu_imm(2'b10);
    cyc();
    reg_wb(1'b0, 3'b011);
    cyc();
    expect_out("andi_r0", K_WDATA, 16'h0004);
    cyc();

    // move_to R5, not, move_from R5
    load_r0(16'h00FF);
    load_ir(16'h0A00);
    reg_wb(1'b1, 3'b001);
    reg_wb(1'b0, 3'b100);
    cyc();
    expect_out("not_r0", K_WDATA, 16'hFF00);
    cyc();
    reg_wb(1'b0, 3'b010);
    cyc();
    expect_out("move_from_r0", K_WDATA, 16'h00FF);
    alu_src_a = 1'b1;
    alu_op    = 2'b01;
    expect_out("r0_eq_r5_zero", K_ZERO, 16'h0001);
    cyc();
    ctl_idle();

    // brz taken: R0 == R3 == 9
    jump_ir(16'h0201);
    expect_out("pc_set_201", K_ADR, 16'h0201);
    load_r0(16'h0009);
    load_ir(16'h0600);
    reg_wb(1'b1, 3'b001);
    load_ir(16'h46F0);
    cyc();
    brz_ctl();
    expect_out("brz_eq_zero", K_ZERO, 16'h0001);
    cyc();
    ctl_idle();
    expect_out("brz_taken_pc", K_ADR, 16'h02F0);
    cyc();

    // brz not taken: R3 = 8
    jump_ir(16'h0201);
    load_r0(16'h0008);
    load_ir(16'h0600);
    reg_wb(1'b1, 3'b001);
    load_r0(16'h0009);
    load_ir(16'h46F0);
    cyc();
    brz_ctl();
    expect_out("brz_ne_zero", K_ZERO, 16'h0000);
    cyc();
    ctl_idle();
    expect_out("brz_not_taken_pc", K_ADR, 16'h0201);
    cyc();

    // pc_write overrides an untaken conditional write
    brz_ctl();
    pc_write = 1'b1;
    pc_sel   = 2'b01;
    cyc();
    ctl_idle();
    expect_out("pc_write_wins", K_ADR, 16'h06F0);
    cyc();

    // jump and PC wrap
    jump_ir(16'h2ABC);
    n_cmp++;
    if (mem_adr !== 12'hABC) begin
      n_fail++;
      $display("FAIL direct_jump_pc: got 0x%03h, want 0xabc", mem_adr);
    end
    expect_out("jump_pc", K_ADR, 16'h0ABC);
    cyc();
    jump_ir(16'h0FFF);
    expect_out("pc_fff", K_ADR, 16'h0FFF);
    cyc();
    fetch_ctl(16'h0000);
    cyc();
    ctl_idle();
    n_cmp++;
    if (mem_adr !== 12'h000) begin
      n_fail++;
      $display("FAIL direct_pc_wrap: got 0x%03h, want 0x000", mem_adr);
    end
    expect_out("pc_wrap", K_ADR, 16'h0000);
    expect_out("wrap_inst", K_INST, 16'h0000);
    cyc();

    // Asynchronous reset mid-cycle with live state
    jump_ir(16'h0ABC);
    cyc();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_adr !== 12'h000) begin
      n_fail++;
      $display("FAIL direct_midreset_adr: got 0x%03h, want 0x000", mem_adr);
    end
    n_cmp++;
    if (inst !== 16'h0000) begin
      n_fail++;
      $display("FAIL direct_midreset_inst: got 0x%04h, want 0x0000", inst);
    end
    expect_out("midreset_adr", K_ADR, 16'h0000);
    expect_out("midreset_inst", K_INST, 16'h0000);
    expect_out("midreset_wdata", K_WDATA, 16'h0000);
    expect_out("midreset_zero", K_ZERO, 16'h0001);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no sample, want 0x%04h", e.name, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
